// File: rtl/weight_loader.sv
// Purpose : fetches num_tiles 2x2 weight tiles from weight_memory and streams them
//           into the systolic array one row per handshake, bottom row (t3,t4) first.
// Latency : start -> FETCH next cycle -> first row valid one cycle later; 3 cycles/tile.
// Backpr. : a row is held (valid high, data stable) until wl_ready; nothing is dropped.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               one-cycle request, honoured only when idle
//   base_addr/num_tiles request parameters, sampled with start
//   mem_addr, mem_w1..4 combinational read port of weight_memory (words addr..addr+3)
//   wl_col0/wl_col1     row data for array columns 0/1
//   wl_valid/wl_ready   row handshake; wl_last marks a tile's top row
//   busy, done          busy outside IDLE; done pulses once per completed request
module weight_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_tiles,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_w1,
    input  logic [DATA_W-1:0] mem_w2,
    input  logic [DATA_W-1:0] mem_w3,
    input  logic [DATA_W-1:0] mem_w4,
    output logic [DATA_W-1:0] wl_col0,
    output logic [DATA_W-1:0] wl_col1,
    output logic              wl_valid,
    output logic              wl_last,
    input  logic              wl_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        SEND_HI = 3'd2,
        SEND_LO = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] t1, t2, t3, t4;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = mem_addr;
        wl_valid = 1'b0;
        wl_last  = 1'b0;
        wl_col0  = '0;
        wl_col1  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_tiles != '0) begin
                        addr_d  = base_addr;
                        cnt_d   = num_tiles;
                        state_d = FETCH;
                    end else begin
                        // empty request: complete without touching memory
                        state_d = FIN;
                    end
                end
            end
            FETCH: state_d = SEND_HI;
            SEND_HI: begin
                wl_valid = 1'b1;
                wl_col0  = t3;
                wl_col1  = t4;
                if (wl_ready) state_d = SEND_LO;
            end
            SEND_LO: begin
                wl_valid = 1'b1;
                wl_last  = 1'b1;
                wl_col0  = t1;
                wl_col1  = t2;
                if (wl_ready) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        // wraps modulo 2^ADDR_W by width truncation
                        addr_d  = mem_addr + ADDR_W'(4);
                        state_d = FETCH;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mem_addr <= '0;
            t1       <= '0;
            t2       <= '0;
            t3       <= '0;
            t4       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_addr <= addr_d;
            // memory words matter only while mem_addr is being presented in FETCH
            if (state_q == FETCH) begin
                t1 <= mem_w1;
                t2 <= mem_w2;
                t3 <= mem_w3;
                t4 <= mem_w4;
            end
            // busy/done are registered views of the state being entered
            busy <= (state_d != IDLE);
            done <= (state_d == FIN);
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [7:0]  num_tiles;
    logic [12:0] mem_addr;
    logic [7:0]  mem_w1, mem_w2, mem_w3, mem_w4;
    logic [7:0]  wl_col0, wl_col1;
    logic        wl_valid, wl_last, wl_ready, busy, done;

    weight_loader #(.DATA_W(8), .ADDR_W(13), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .mem_addr(mem_addr),
        .mem_w1(mem_w1), .mem_w2(mem_w2), .mem_w3(mem_w3), .mem_w4(mem_w4),
        .wl_col0(wl_col0), .wl_col1(wl_col1), .wl_valid(wl_valid),
        .wl_last(wl_last), .wl_ready(wl_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // weight memory: word i holds (i+1) mod 256
    logic [7:0]  mem [0:8191];
    logic [12:0] a1, a2, a3;
    assign a1 = mem_addr + 13'd1;
    assign a2 = mem_addr + 13'd2;
    assign a3 = mem_addr + 13'd3;
    assign mem_w1 = mem[mem_addr];
    assign mem_w2 = mem[a1];
    assign mem_w3 = mem[a2];
    assign mem_w4 = mem[a3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic        last;
        logic [12:0] addr;
    } row_t;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural model + compare ----------------
    row_t exp_q[$];
    row_t obs_q[$];
    bit   active = 0;
    int   start_c = 0;
    int   next_row = 0;
    int   done_due = -1;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;

    always @(negedge clk) begin
        bit   valid_exp;
        row_t r;
        row_t o;
        logic [12:0] ta;
        if (!reset) begin
            chk("rst_mem_addr", int'(mem_addr), 0);
            chk("rst_col0", int'(wl_col0), 0);
            chk("rst_col1", int'(wl_col1), 0);
            chk("rst_valid", int'(wl_valid), 0);
            chk("rst_last", int'(wl_last), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            exp_q.delete();
            active   = 0;
            done_due = -1;
        end else begin
            valid_exp = active && (exp_q.size() > 0) && (cyc >= next_row);
            chk("busy", int'(busy), int'(active && (cyc > start_c)));
            chk("done", int'(done), int'(cyc == done_due));
            chk("wl_valid", int'(wl_valid), int'(valid_exp));
            if (wl_valid && wl_ready) begin
                o.c0 = wl_col0; o.c1 = wl_col1; o.last = wl_last; o.addr = mem_addr;
                obs_q.push_back(o);
            end
            if (valid_exp) begin
                r = exp_q[0];
                chk("row_col0", int'(wl_col0), int'(r.c0));
                chk("row_col1", int'(wl_col1), int'(r.c1));
                chk("row_last", int'(wl_last), int'(r.last));
                chk("row_mem_addr", int'(mem_addr), int'(r.addr));
                if (wl_ready) begin
                    void'(exp_q.pop_front());
                    if (!r.last)               next_row = cyc + 1;
                    else if (exp_q.size() > 0) next_row = cyc + 2;
                    else                       done_due = cyc + 1;
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (start && !active) begin
                active   = 1;
                start_c  = cyc;
                next_row = cyc + 2;
                for (int i = 0; i < int'(num_tiles); i++) begin
                    ta = base_addr + 13'(4 * i);
                    r.c0 = mem[ta + 13'd2]; r.c1 = mem[ta + 13'd3]; r.last = 1'b0; r.addr = ta;
                    exp_q.push_back(r);
                    r.c0 = mem[ta];         r.c1 = mem[ta + 13'd1]; r.last = 1'b1; r.addr = ta;
                    exp_q.push_back(r);
                end
                done_due = (num_tiles == 8'd0) ? cyc + 1 : -1;
            end else if (cyc == done_due) begin
                active   = 0;
                done_due = -1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int t0;
    int done_base;

    task automatic do_start(input int b, input int n);
        @(posedge clk);
        #1;
        obs_q.delete();
        busy_cnt  = 0;
        done_base = done_cnt;
        start     = 1'b1;
        base_addr = 13'(b);
        num_tiles = 8'(n);
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_timeout", int'(done_cnt != done_base), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rows(input string nm, input int e[$]);
        chk({nm, "_count"}, obs_q.size(), e.size() / 2);
        for (int i = 0; i < obs_q.size() && 2 * i + 1 < e.size(); i++) begin
            chk({nm, "_c0"}, int'(obs_q[i].c0), e[2 * i]);
            chk({nm, "_c1"}, int'(obs_q[i].c1), e[2 * i + 1]);
            chk({nm, "_last"}, int'(obs_q[i].last), i % 2);
        end
    endtask

    initial begin
        int d0;
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_tiles = '0;
        wl_ready  = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);

        // test 4: empty request
        do_start(0, 0);
        wait_done(20);
        chk("t4_done_lat", last_done_cyc - t0, 1);
        chk("t4_busy_cycles", busy_cnt, 1);
        chk("t4_rows", obs_q.size(), 0);
        chk("t4_mem_addr", int'(mem_addr), 0);

        // test 1: one tile; a start coinciding with done is ignored
        do_start(0, 1);
        d0 = done_base;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 13'd40; num_tiles = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t1_done_lat", last_done_cyc - t0, 4);
        chk("t1_busy_cycles", busy_cnt, 4);
        chk("t1_one_done", done_cnt - d0, 1);
        chk("t1_idle_after", int'(busy), 0);
        check_rows("t1_rows", '{3, 4, 1, 2});

        // test 2: two tiles, ready always high
        do_start(0, 2);
        wait_done(50);
        chk("t2_done_lat", last_done_cyc - t0, 7);
        check_rows("t2_rows", '{3, 4, 1, 2, 7, 8, 5, 6});
        if (obs_q.size() > 2) chk("t2_addr_tile2", int'(obs_q[2].addr), 4);
        else chk("t2_addr_tile2_present", obs_q.size(), 4);

        // test 3: three stalled cycles in the first SEND_HI
        do_start(0, 2);
        @(posedge clk);
        #1 wl_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_hold_valid", int'(wl_valid), 1);
        chk("t3_hold_col0", int'(wl_col0), 3);
        chk("t3_hold_col1", int'(wl_col1), 4);
        @(posedge clk);
        @(posedge clk);
        #1 wl_ready = 1'b1;
        wait_done(50);
        chk("t3_done_lat", last_done_cyc - t0, 10);
        check_rows("t3_rows", '{3, 4, 1, 2, 7, 8, 5, 6});

        // test 5: address wrap at the top of memory
        do_start(8188, 2);
        wait_done(50);
        check_rows("t5_rows", '{255, 0, 253, 254, 3, 4, 1, 2});
        if (obs_q.size() > 2) begin
            chk("t5_addr_tile1", int'(obs_q[0].addr), 8188);
            chk("t5_addr_wrap", int'(obs_q[2].addr), 0);
        end else chk("t5_rows_present", obs_q.size(), 4);

        // test 6: reset in SEND_LO of tile 1, then a clean run with a busy-time start
        do_start(0, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_pre_last", int'(wl_last), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", int'(wl_valid), 0);
        chk("t6_rst_col0", int'(wl_col0), 0);
        chk("t6_rst_busy", int'(busy), 0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        do_start(0, 1);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 13'd100; num_tiles = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(50);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_done_lat", last_done_cyc - t0, 4);
        chk("t6_one_done", done_cnt - done_base, 1);
        check_rows("t6_rows", '{3, 4, 1, 2});

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
